// File: rtl/nibble_serial_add_sub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// Holds the controller state encoding and the operation mode constants.
package nibble_serial_add_sub_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage : nibble_serial_add_sub_ctrl_pkg

// File: rtl/nibble_serial_add_sub_ctrl_slice.sv
// Purely combinational 4-bit ripple-carry adder slice.
// It exposes the carry into bit 3 so the controller can derive signed overflow.
module add_sub_nibble_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       c3,
   output logic       c4
);

   logic [4:0] w_c;

   // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      w_c    = '0;
      s      = '0;
      w_c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         s[i]       = a[i] ^ b[i] ^ w_c[i];
         w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
      c3 = w_c[3];
      c4 = w_c[4];
   end

endmodule : add_sub_nibble_slice

// File: rtl/nibble_serial_add_sub_ctrl.sv
// Multi-precision add/subtract sequencer: one shared 4-bit slice, one nibble per
// cycle LSB first, with a start/busy/done handshake and held result flags.
module nibble_serial_add_sub_ctrl
   import nibble_serial_add_sub_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   mode,
   input  logic [4*NIBBLES-1:0]   a_in,
   input  logic [4*NIBBLES-1:0]   b_in,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   carry_out,
   output logic                   overflow,
   output logic                   zero
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_t             r_state;
   state_t             w_next_state;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic               r_mode;
   logic               r_carry;
   logic [IDX_W-1:0]   r_idx;
   logic [W-1:0]       r_result;
   logic               r_carry_out;
   logic               r_overflow;
   logic               r_zero;

   logic               w_accept;
   logic               w_last;
   logic [3:0]         w_a_nib;
   logic [3:0]         w_b_nib;
   logic [3:0]         w_sum;
   logic               w_c3;
   logic               w_c4;
   logic [W-1:0]       w_result_next;

   // Start is honoured only outside RUN, so back-to-back ops can launch from DONE.
   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));

   // Subtract is A + ~B + 1: the +1 enters as the initial carry latched with start.
   assign w_a_nib  = r_a[4*r_idx +: 4];
   assign w_b_nib  = r_b[4*r_idx +: 4] ^ {4{r_mode}};

   add_sub_nibble_slice u_slice (
      .a   (w_a_nib),
      .b   (w_b_nib),
      .cin (r_carry),
      .s   (w_sum),
      .c3  (w_c3),
      .c4  (w_c4)
   );

   always_comb begin
      w_result_next                = r_result;
      w_result_next[4*r_idx +: 4]  = w_sum;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start) w_next_state = RUN;
         RUN:     if (w_last) w_next_state = DONE;
         DONE:    w_next_state = start ? RUN : IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state == RUN);
      done      = (r_state == DONE);
      result    = r_result;
      carry_out = r_carry_out;
      overflow  = r_overflow;
      zero      = r_zero;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_mode      <= MODE_ADD;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_accept) begin
         r_a         <= a_in;
         r_b         <= b_in;
         r_mode      <= mode;
         r_carry     <= mode;
         r_idx       <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
      end else if (r_state == RUN) begin
         r_result <= w_result_next;
         r_carry  <= w_c4;
         r_idx    <= r_idx + IDX_W'(1);
         if (w_last) begin
            r_carry_out <= w_c4;
            r_overflow  <= w_c3 ^ w_c4;
            r_zero      <= (w_result_next == '0);
         end
      end
   end

endmodule : nibble_serial_add_sub_ctrl

// File: tb/tb_nibble_serial_add_sub_ctrl.sv
// Self-checking bench for nibble_serial_add_sub_ctrl: directed handshake cases plus
// random operations compared against a plain-arithmetic reference model.
module tb_nibble_serial_add_sub_ctrl;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          clk;
   logic          rst;
   logic          start;
   logic          mode;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          carry_out;
   logic          overflow;
   logic          zero;

   int            n_pass  = 0;
   int            n_total = 0;

   nibble_serial_add_sub_ctrl #(.NIBBLES(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .a_in      (a_in),
      .b_in      (b_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference model: plain integer arithmetic on the whole operands.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        output logic [W-1:0] r, output logic c, output logic v, output logic z);
      longint sa, sb, st;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (m) begin
         r  = a - b;
         c  = (a >= b);
         st = sa - sb;
      end else begin
         r  = a + b;
         c  = ((longint'(a) + longint'(b)) >= (longint'(1) << W));
         st = sa + sb;
      end
      v = (st > ((longint'(1) << (W - 1)) - 1)) || (st < -(longint'(1) << (W - 1)));
      z = (r == '0);
   endtask

   // Launch one op. b2b=1 drives start in the current (DONE) cycle instead of the next one.
   // inject_at > 0 pulses a spurious start with other operands in that RUN cycle.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input bit b2b, input int inject_at);
      logic [W-1:0] er;
      logic         ec, ev, ez;
      model(a, b, m, er, ec, ev, ez);
      if (!b2b) @(negedge clk);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      mode  = m;
      @(posedge clk);
      for (int c = 1; c <= N; c++) begin
         @(negedge clk);
         if (c == inject_at) begin
            start = 1'b1;
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            mode  = ~m;
         end else begin
            start = 1'b0;
         end
         check({tag, " busy"}, 32'(busy), 32'd1);
         check({tag, " done_early"}, 32'(done), 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy_off"}, 32'(busy), 32'd0);
      check({tag, " result"}, 32'(result), 32'(er));
      check({tag, " carry"}, 32'(carry_out), 32'(ec));
      check({tag, " ovf"}, 32'(overflow), 32'(ev));
      check({tag, " zero"}, 32'(zero), 32'(ez));
   endtask

   task automatic check_idle_after(input string tag, input logic [W-1:0] exp_r);
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(done), 32'd0);
      check({tag, " idle_busy"}, 32'(busy), 32'd0);
      check({tag, " held"}, 32'(result), 32'(exp_r));
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      rst = 1'b0;

      run_op("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
      check_idle_after("add", 16'h2233);
      run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 0);
      run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
      run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 0);
      run_op("wrap_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      run_op("sub_zero", 16'hABCD, 16'hABCD, 1'b1, 1'b0, 0);

      // Start during RUN must be ignored.
      run_op("ignore_start", 16'h4321, 16'h1111, 1'b0, 1'b0, 2);
      // Back-to-back start from the DONE cycle.
      run_op("b2b", 16'h0001, 16'h0001, 1'b0, 1'b1, 0);
      check_idle_after("b2b", 16'h0002);

      // Reset in cycle 2 of RUN discards the partial result.
      @(negedge clk);
      start = 1'b1;
      a_in  = 16'h1111;
      b_in  = 16'h2222;
      mode  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      check("midrst result", 32'(result), 32'd0);
      check("midrst flags", {29'd0, carry_out, overflow, zero}, 32'd0);
      for (int c = 0; c < N + 2; c++) begin
         @(negedge clk);
         check("midrst no_done", 32'(done), 32'd0);
      end
      run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

      for (int k = 0; k < 24; k++) begin
         run_op($sformatf("rand%0d", k), W'($urandom), W'($urandom), 1'($urandom),
                (k % 3) == 1, ((k % 5) == 2) ? int'($urandom_range(1, N)) : 0);
      end
      check_idle_after("final", result);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule : tb_nibble_serial_add_sub_ctrl

// File: doc/nibble_serial_add_sub_ctrl.md
Name: nibble_serial_add_sub_ctrl

Overview:
Sequencer that performs multi-precision add/subtract on W = 4*NIBBLES bit operands by time-sharing one 4-bit add/sub slice. It processes one nibble per cycle, least significant nibble first, and chains the carry between nibbles in a register. Start/busy/done handshake with the surrounding lab datapath; result, carry, overflow and zero flags are held until the next operation.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; W = 4*NIBBLES; legal range 1..8

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
start  input  1  request a new operation; sampled only when not busy
mode  input  1  0 = add (A+B), 1 = subtract (A-B); latched with start
a_in  input  W  operand A; latched with start
b_in  input  W  operand B; latched with start
busy  output  1  high while nibbles are being processed
done  output  1  one-cycle pulse when result and flags become valid
result  output  W  sum/difference, held until next accepted start
carry_out  output  1  carry from MSB nibble; for subtract, 1 = no borrow (A >= B unsigned)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
zero  output  1  result == 0

Behaviour:
- Reset, synchronous, active-high: state IDLE. busy, done, result, carry_out, overflow and zero are all 0. Operand, mode, carry and index registers are 0. Reset has priority over everything, including mid-RUN; the partial result is discarded.
- States:
  - IDLE: waiting for start.
  - RUN: one nibble per cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- IDLE or DONE with start=1:
  - Latch a_in, b_in and mode.
  - Set carry_reg = mode (the +1 for two's-complement subtract) and idx = 0.
  - Clear result, carry_out, overflow and zero.
  - Go to RUN.
- Start in DONE is accepted (back-to-back operations). Start in RUN is ignored and its operands are not sampled.
- RUN, each cycle:
  - Slice inputs: A nibble idx, B nibble idx XOR {4{mode}}, carry-in = carry_reg.
  - Write the slice sum into result[4*idx+3 : 4*idx].
  - carry_reg <= slice c4; idx <= idx+1.
  - When idx == NIBBLES-1, also register carry_out = c4, overflow = c3 ^ c4 and zero = (full result including this nibble == 0), then go to DONE.
- busy = (state == RUN), decoded from registered state.
- Latency: start sampled at the edge ending cycle 0. busy is high in cycles 1..NIBBLES. done is high in cycle NIBBLES+1, and result and flags are valid from that cycle on.
- result changes nibble-by-nibble during RUN and is not valid until done.
- Width: idx is clog2(NIBBLES) bits, minimum 1. Arithmetic is modulo 2^W; no saturation.
- NIBBLES=1: RUN lasts one cycle and the behaviour is identical to a single slice.

Decomposition:
- Shared package: state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2; mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- One sub-module, add_sub_nibble_slice: purely combinational 4-bit ripple add.
  - Inputs: a[3:0], b[3:0] (already conditionally inverted), cin.
  - Outputs: s[3:0], c3 (carry into bit 3), c4 (carry out of bit 3).
  - Instantiated once; the controller owns the B-inversion XOR and the carry register.

Test Plan:
- Add, NIBBLES=4: a_in=0x1234, b_in=0x0FFF, mode=0 -> busy cycles 1-4, done pulse cycle 5; result=0x2233, carry_out=0, overflow=0, zero=0.
- Subtract with borrow: a_in=0x0005, b_in=0x0007, mode=1 -> result=0xFFFE, carry_out=0, overflow=0, zero=0.
- Signed overflow:
  - 0x7FFF+0x0001, mode=0 -> result=0x8000, overflow=1, carry_out=0.
  - 0x8000-0x0001, mode=1 -> result=0x7FFF, overflow=1, carry_out=1.
- Wrap and zero: 0xFFFF+0x0001, mode=0 -> result=0x0000, carry_out=1, zero=1, overflow=0.
- Handshake:
  - start with new operands in cycle 2 of RUN -> ignored; the original result is produced.
  - start in the DONE cycle with 0x0001+0x0001 -> accepted; next done shows 0x0002.
- Reset mid-op: assert rst in cycle 2 of RUN -> next cycle busy=0, done=0, result=0, all flags 0, and no done pulse follows. A subsequent start with 0x00FF+0x0001 gives 0x0100 in the normal 5 cycles.
